// File: rtl/reset_sequencer.sv
// Board bring-up reset sequencer: waits for a stable PLL lock, pulses the
// Ethernet PHY reset, then releases DDR, MAC and application resets in order.
// Loss of lock or a user reset aborts back to WAIT_LOCK with every reset
// reasserted. All outputs are registered and decoded from the next state.
module reset_sequencer #(
  parameter int unsigned LOCK_CYCLES     = 1000,
  parameter int unsigned PHY_RST_CYCLES  = 1000000,
  parameter int unsigned PHY_WAIT_CYCLES = 500000,
  parameter int unsigned GAP_CYCLES      = 16,
  parameter int unsigned CALIB_TIMEOUT   = 2000000,
  parameter int unsigned CNT_W           = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked_in,
  input  logic       sw_rst_in,
  input  logic       calib_done_in,
  output logic       phy_rst_n_out,
  output logic       rst_ddr_out,
  output logic       rst_mac_out,
  output logic       rst_app_out,
  output logic       sys_ready_out,
  output logic [2:0] state_out,
  output logic [7:0] fault_count_out
);

  typedef enum logic [2:0] {
    ST_WAIT_LOCK   = 3'd0,
    ST_LOCK_STABLE = 3'd1,
    ST_PHY_RST     = 3'd2,
    ST_PHY_WAIT    = 3'd3,
    ST_DDR         = 3'd4,
    ST_MAC         = 3'd5,
    ST_APP         = 3'd6,
    ST_RUN         = 3'd7
  } state_t;

  // Last counter value of each timed phase (a phase of N cycles ends at N-1).
  localparam logic [CNT_W-1:0] LOCK_LAST_C  = CNT_W'(LOCK_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] PRST_LAST_C  = CNT_W'(PHY_RST_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] PWAIT_LAST_C = CNT_W'(PHY_WAIT_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] GAP_LAST_C   = CNT_W'(GAP_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CALIB_LAST_C = CNT_W'(CALIB_TIMEOUT - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE_C    = CNT_W'(32'd1);

  // Output pattern {phy_rst_n, rst_ddr, rst_mac, rst_app, sys_ready} for a
  // state; the released set only grows as the sequence advances.
  function automatic logic [4:0] decode_outputs(input state_t s);
    logic [4:0] o;
    case (s)
      ST_WAIT_LOCK:   o = 5'b0_111_0;
      ST_LOCK_STABLE: o = 5'b0_111_0;
      ST_PHY_RST:     o = 5'b0_111_0;
      ST_PHY_WAIT:    o = 5'b1_111_0;
      ST_DDR:         o = 5'b1_011_0;
      ST_MAC:         o = 5'b1_001_0;
      ST_APP:         o = 5'b1_000_0;
      ST_RUN:         o = 5'b1_000_1;
      default:        o = 5'b0_111_0;
    endcase
    return o;
  endfunction

  state_t           state_r;
  state_t           next_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [7:0]       fault_r;
  logic [4:0]       outs_r;
  logic             abort_s;
  logic             fault_inc_s;
  logic             timed_s;

  // Next-state selection; abort and calibration timeout win over progress.
  always_comb begin
    next_state_s = state_r;
    fault_inc_s  = 1'b0;
    abort_s      = ~pll_locked_in | sw_rst_in;
    timed_s      = (state_r != ST_WAIT_LOCK) && (state_r != ST_RUN);
    if ((state_r >= ST_PHY_RST) && abort_s) begin
      next_state_s = ST_WAIT_LOCK;
      fault_inc_s  = ~pll_locked_in;
    end else begin
      case (state_r)
        ST_WAIT_LOCK: begin
          if (!abort_s) next_state_s = ST_LOCK_STABLE;
          else          next_state_s = ST_WAIT_LOCK;
        end
        ST_LOCK_STABLE: begin
          if (abort_s)                    next_state_s = ST_WAIT_LOCK;
          else if (cnt_r == LOCK_LAST_C)  next_state_s = ST_PHY_RST;
          else                            next_state_s = ST_LOCK_STABLE;
        end
        ST_PHY_RST: begin
          if (cnt_r == PRST_LAST_C) next_state_s = ST_PHY_WAIT;
          else                      next_state_s = ST_PHY_RST;
        end
        ST_PHY_WAIT: begin
          if (cnt_r == PWAIT_LAST_C) next_state_s = ST_DDR;
          else                       next_state_s = ST_PHY_WAIT;
        end
        ST_DDR: begin
          if (cnt_r == CALIB_LAST_C) begin
            next_state_s = ST_WAIT_LOCK;
            fault_inc_s  = 1'b1;
          end else if (calib_done_in) begin
            next_state_s = ST_MAC;
          end else begin
            next_state_s = ST_DDR;
          end
        end
        ST_MAC: begin
          if (cnt_r == GAP_LAST_C) next_state_s = ST_APP;
          else                     next_state_s = ST_MAC;
        end
        ST_APP: begin
          if (cnt_r == GAP_LAST_C) next_state_s = ST_RUN;
          else                     next_state_s = ST_APP;
        end
        ST_RUN:  next_state_s = ST_RUN;
        default: next_state_s = ST_WAIT_LOCK;
      endcase
    end
  end

  // State, phase counter, fault counter and registered output pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_WAIT_LOCK;
      cnt_r   <= '0;
      fault_r <= 8'd0;
      outs_r  <= 5'b0_111_0;
    end else begin
      state_r <= next_state_s;
      if (next_state_s != state_r) cnt_r <= '0;
      else if (timed_s)            cnt_r <= cnt_r + CNT_ONE_C;
      else                         cnt_r <= '0;
      if (fault_inc_s && (fault_r != 8'hFF)) fault_r <= fault_r + 8'd1;
      else                                   fault_r <= fault_r;
      outs_r <= decode_outputs(next_state_s);
    end
  end

  assign state_out       = state_r;
  assign fault_count_out = fault_r;
  assign phy_rst_n_out   = outs_r[4];
  assign rst_ddr_out     = outs_r[3];
  assign rst_mac_out     = outs_r[2];
  assign rst_app_out     = outs_r[1];
  assign sys_ready_out   = outs_r[0];

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer with short phase lengths.
// Expected behaviour comes from a timeline model: the sequence start time and
// the DDR-complete time determine the expected phase by plain arithmetic.
module tb_reset_sequencer;

  localparam int LOCK = 4, PRST = 8, PWAIT = 6, GAP = 3, CAL = 20;

  logic       clk = 1'b0;
  logic       rst_n, pll, sw, calib;
  logic       phy_rst_n, rst_ddr, rst_mac, rst_app, sys_ready;
  logic [2:0] state;
  logic [7:0] fault;

  int checks = 0;
  int errors = 0;

  reset_sequencer #(
    .LOCK_CYCLES(LOCK), .PHY_RST_CYCLES(PRST), .PHY_WAIT_CYCLES(PWAIT),
    .GAP_CYCLES(GAP), .CALIB_TIMEOUT(CAL), .CNT_W(24)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked_in(pll), .sw_rst_in(sw),
    .calib_done_in(calib), .phy_rst_n_out(phy_rst_n), .rst_ddr_out(rst_ddr),
    .rst_mac_out(rst_mac), .rst_app_out(rst_app), .sys_ready_out(sys_ready),
    .state_out(state), .fault_count_out(fault)
  );

  always #5 clk = ~clk;

  // ---------------- timeline reference model ----------------
  bit m_active = 1'b0;
  int m_s = 0;       // edge that entered LOCK_STABLE
  int m_m = -1;      // edge that entered MAC, -1 while still in DDR
  int m_fault = 0;
  int t = -1;        // index of the last clock edge taken

  function automatic int phase_of(int tt);
    int e, em;
    if (!m_active) return 0;
    e = tt - m_s;
    if (e < LOCK) return 1;
    if (e < LOCK + PRST) return 2;
    if (e < LOCK + PRST + PWAIT) return 3;
    if (m_m < 0) return 4;
    em = tt - m_m;
    if (em < GAP) return 5;
    if (em < 2 * GAP) return 6;
    return 7;
  endfunction

  function automatic logic [15:0] exp_vec(int st, int f);
    logic [2:0] s3;
    logic [7:0] f8;
    s3 = st[2:0];
    f8 = f[7:0];
    return {s3, (st >= 3), (st < 4), (st < 5), (st < 6), (st == 7), f8};
  endfunction

  function automatic logic [15:0] dut_vec();
    return {state, phy_rst_n, rst_ddr, rst_mac, rst_app, sys_ready, fault};
  endfunction

  task automatic model_edge(input logic l, input logic s, input logic c);
    int cur;
    cur = phase_of(t - 1);
    if (!m_active) begin
      if (l && !s) begin m_active = 1'b1; m_s = t; m_m = -1; end
    end else if (!l || s) begin
      m_active = 1'b0;
      if (cur >= 2 && !l && m_fault < 255) m_fault++;
    end else if (cur == 4) begin
      if (t - (m_s + LOCK + PRST + PWAIT) == CAL) begin
        m_active = 1'b0;
        if (m_fault < 255) m_fault++;
      end else if (c) begin
        m_m = t;
      end
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_m = -1; m_fault = 0;
  endtask

  task automatic check_vec(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d: got st=%0d phy_n=%b ddr=%b mac=%b app=%b rdy=%b flt=%0d, expected st=%0d phy_n=%b ddr=%b mac=%b app=%b rdy=%b flt=%0d",
               name, t, act[15:13], act[12], act[11], act[10], act[9], act[8], act[7:0],
               exp[15:13], exp[12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0d: got %0d expected %0d", name, t, act, exp);
    end
  endtask

  // One clock: drive at negedge, take the edge, update model, compare at negedge.
  task automatic step(input logic l, input logic s, input logic c);
    pll = l; sw = s; calib = c;
    @(posedge clk);
    t++;
    model_edge(l, s, c);
    @(negedge clk);
    check_vec("model", dut_vec(), exp_vec(phase_of(t), m_fault));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_vec("reset_state", dut_vec(), exp_vec(0, 0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    int         edge_n;
    logic [15:0] exp;
  } vec_t;

  vec_t tab[13];
  int   base;

  initial begin
    rst_n = 1'b0; pll = 1'b0; sw = 1'b0; calib = 1'b0;

    // Nominal bring-up with lock and calibration present from the start.
    tab[0]  = '{0,  exp_vec(1, 0)};
    tab[1]  = '{3,  exp_vec(1, 0)};
    tab[2]  = '{4,  exp_vec(2, 0)};
    tab[3]  = '{11, exp_vec(2, 0)};
    tab[4]  = '{12, exp_vec(3, 0)};
    tab[5]  = '{17, exp_vec(3, 0)};
    tab[6]  = '{18, exp_vec(4, 0)};
    tab[7]  = '{19, exp_vec(5, 0)};
    tab[8]  = '{21, exp_vec(5, 0)};
    tab[9]  = '{22, exp_vec(6, 0)};
    tab[10] = '{24, exp_vec(6, 0)};
    tab[11] = '{25, exp_vec(7, 0)};
    tab[12] = '{30, exp_vec(7, 0)};

    apply_reset();
    base = t + 1;
    for (int i = 0; i < 13; i++) begin
      while (t - base < tab[i].edge_n) step(1'b1, 1'b0, 1'b1);
      check_vec($sformatf("nominal_e%0d", tab[i].edge_n), dut_vec(), tab[i].exp);
    end

    // Brief lock loss during LOCK_STABLE: back to WAIT_LOCK, no fault, restart.
    apply_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check_int("lockdrop_state", int'(state), 0);
    check_int("lockdrop_fault", int'(fault), 0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    check_int("restart_still_stable", int'(state), 1);
    step(1'b1, 1'b0, 1'b0);
    check_int("restart_phy_rst", int'(state), 2);

    // Calibration never completes: 20 cycles in DDR then a counted abort.
    apply_reset();
    for (int i = 0; i < 19; i++) step(1'b1, 1'b0, 1'b0);
    check_int("ddr_entry", int'(state), 4);
    for (int i = 0; i < 19; i++) step(1'b1, 1'b0, 1'b0);
    check_int("ddr_last_cycle", int'(state), 4);
    step(1'b1, 1'b0, 1'b0);
    check_vec("calib_timeout", dut_vec(), exp_vec(0, 1));

    // User reset while running: immediate full reassert, fault unchanged.
    for (int i = 0; i < 26; i++) step(1'b1, 1'b0, 1'b1);
    check_int("run_reached", int'(state), 7);
    step(1'b1, 1'b1, 1'b1);
    check_vec("sw_abort_run", dut_vec(), exp_vec(0, 1));
    step(1'b0, 1'b0, 1'b0);

    // Repeated lock-loss aborts from PHY_RST saturate the fault counter.
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    check_int("fault_saturated", int'(fault), 255);

    // Asynchronous reset in the middle of PHY_RST.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    check_int("pre_async_phy_rst", int'(state), 2);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_vec("async_reset", dut_vec(), exp_vec(0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    check_int("resume_after_reset", int'(state), 1);

    // Randomized traffic against the timeline model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 299) == 0),
           ($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
